chunked_adder: RTL and testbench



---
 rtl/chunked_adder_pkg.sv | 16 +
 rtl/chunked_adder_slice.sv | 21 ++
 rtl/chunked_adder.sv | 142 ++++++++++++++
 tb/tb_chunked_adder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder/subtractor.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Returns 0 for an illegal N/W pairing so the instantiating module can reject it.
  function automatic int unsigned slice_count(input int unsigned n, input int unsigned w);
    if (w == 0 || n == 0 || (n % w) != 0) return 0;
    return n / w;
  endfunction

endpackage

// File: rtl/chunked_adder_slice.sv
// W-bit combinational slice: {co, s} = x + y + ci.
module slice_adder #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] total;

  always_comb begin
    total = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, ci_i};
  end

  assign s_o  = total[W-1:0];
  assign co_o = total[W];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle N-bit adder/subtractor processing W bits per clock with valid/ready flow control.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned S    = slice_count(N, W);
  localparam int unsigned IDXW = (S > 1) ? $clog2(S) : 1;

  generate
    if (S == 0) begin : g_bad_params
      $error("chunked_adder: N must be a positive multiple of W and W >= 1");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            a_sign_q, a_sign_d;
  logic            b_sign_q, b_sign_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [31:0]     base;
  logic [W-1:0]    slice_x, slice_y, slice_s;
  logic            slice_co;

  assign base    = 32'(idx_q) * W;
  assign slice_x = a_q[base +: W];
  assign slice_y = b_q[base +: W];

  slice_adder #(.W(W)) u_slice (
    .x_i  (slice_x),
    .y_i  (slice_y),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the borrow-in is folded into the initial carry.
          a_d      = a;
          b_d      = sub ? ~b : b;
          carry_d  = cin ^ sub;
          a_sign_d = a[N-1];
          b_sign_d = sub ? ~b[N-1] : b[N-1];
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_d[base +: W] = slice_s;
        carry_d          = slice_co;
        idx_d            = idx_q + 1'b1;
        if (idx_q == IDXW'(S - 1)) begin
          // Flags are taken from the completed sum so they are valid together with out_valid.
          cout_d  = slice_co;
          ovf_d   = (a_sign_q == b_sign_q) && (sum_d[N-1] != a_sign_q);
          zero_d  = (sum_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: directed vectors, flow-control sequences and a parameter sweep.
module tb_chunked_adder;

  logic clk;
  logic rst;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       cin, sub, cout, ovf, zero;

  logic        sw_valid, sw_ready, sw_cin, sw_sub;
  logic [15:0] sw_a, sw_b;
  logic        w8_ir, w8_ov, w8_c, w8_o, w8_z;
  logic [7:0]  w8_s;
  logic        w1_ir, w1_ov, w1_c, w1_o, w1_z;
  logic [7:0]  w1_s;
  logic        n16_ir, n16_ov, n16_c, n16_o, n16_z;
  logic [15:0] n16_s;

  int errors = 0;
  int checks = 0;

  chunked_adder #(.N(8), .W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  chunked_adder #(.N(8), .W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w8_ir), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(w8_ov), .out_ready(sw_ready), .sum(w8_s),
    .cout(w8_c), .ovf(w8_o), .zero(w8_z)
  );

  chunked_adder #(.N(8), .W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(w1_ir), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(w1_ov), .out_ready(sw_ready), .sum(w1_s),
    .cout(w1_c), .ovf(w1_o), .zero(w1_z)
  );

  chunked_adder #(.N(16), .W(4)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(n16_ir), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(n16_ov), .out_ready(sw_ready), .sum(n16_s),
    .cout(n16_c), .ovf(n16_o), .zero(n16_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Full-width reference: returns {ovf, zero, cout, sum[15:0]} for an n-bit operation.
  function automatic logic [18:0] ref_op(input logic [15:0] av, input logic [15:0] bv,
                                         input logic ci, input logic sb, input int n);
    logic [16:0] mask, full;
    logic [15:0] am, bb, sm;
    logic        co;
    mask = (17'd1 << n) - 17'd1;
    am   = av & mask[15:0];
    bb   = (sb ? ~bv : bv) & mask[15:0];
    full = {1'b0, am} + {1'b0, bb} + {16'd0, ci ^ sb};
    sm   = full[15:0] & mask[15:0];
    co   = full[n];
    return {(am[n-1] == bb[n-1]) && (sm[n-1] != am[n-1]), sm == 16'd0, co, sm};
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic sb, output int lat);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~ci; sub = ~sb;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (out_valid) lat = k;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic cmp_sweep(input string tag, input logic [15:0] gs, input logic gc,
                           input logic go, input logic gz, input int lat, input int elat,
                           input logic [18:0] e);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_sum"}, 32'(gs), 32'(e[15:0]));
    check({tag, "_cout"}, 32'(gc), 32'(e[16]));
    check({tag, "_zero"}, 32'(gz), 32'(e[17]));
    check({tag, "_ovf"}, 32'(go), 32'(e[18]));
  endtask

  vec_t vecs[8];
  logic [7:0] b2b_a[3], b2b_b[3], b2b_exp[3];
  logic       b2b_cin[3], b2b_sub[3];

  initial begin
    int lat, seen, acc, res, last_c, lw8, lw1, ln16;
    logic pr, pv;
    logic [7:0] psum;
    logic [18:0] e8, e16;

    vecs[0] = '{8'd40,  8'd6,   1'b0, 1'b0, 8'd46,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'd5,   8'd10,  1'b0, 1'b1, 8'd251, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'd100, 8'd100, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'd200, 8'd55,  1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1};

    b2b_a = '{8'd1, 8'd250, 8'd9};  b2b_b = '{8'd2, 8'd10, 8'd3};
    b2b_cin = '{1'b0, 1'b0, 1'b1};  b2b_sub = '{1'b0, 1'b0, 1'b1};
    b2b_exp = '{8'd3, 8'd4, 8'd5};

    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
    sw_valid = 0; sw_ready = 0; sw_a = 0; sw_b = 0; sw_cin = 0; sw_sub = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      handshake();
    end

    // Reset in the middle of RUN, after the previous result left cout=1 and zero=1.
    a = 8'd200; b = 8'd100; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    // Stall in DONE with a spurious in_valid that must be ignored.
    run_op(8'd40, 8'd6, 1'b0, 1'b0, lat);
    check("stall_lat", 32'(lat), 32'd4);
    a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'd46);
    end
    in_valid = 1'b0;
    handshake();

    // in_valid held through RUN with different operands: result must use the first set.
    a = 8'd10; b = 8'd20; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd99; b = 8'd99;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 2) in_valid = 1'b0;
      if (out_valid) lat = k;
    end
    check("ignore_lat", 32'(lat), 32'd4);
    check("ignore_sum", 32'(sum), 32'd30);
    handshake();

    // Back-to-back with in_valid and out_ready held high.
    acc = 0; res = 0; last_c = 0;
    out_ready = 1'b1;
    a = b2b_a[0]; b = b2b_b[0]; cin = b2b_cin[0]; sub = b2b_sub[0]; in_valid = 1'b1;
    for (int c = 1; c <= 40 && res < 3; c++) begin
      pr = in_ready; pv = out_valid; psum = sum;
      @(posedge clk); #1;
      if (pv) begin
        check($sformatf("b2b%0d_sum", res), 32'(psum), 32'(b2b_exp[res]));
        if (res > 0) check($sformatf("b2b%0d_spacing", res), 32'(c - last_c), 32'd6);
        last_c = c;
        res++;
      end
      if (pr && in_valid) begin
        acc++;
        if (acc < 3) begin
          a = b2b_a[acc]; b = b2b_b[acc]; cin = b2b_cin[acc]; sub = b2b_sub[acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_results", 32'(res), 32'd3);
    check("b2b_accepts", 32'(acc), 32'd3);

    // Parameter sweep across three configurations driven in lockstep.
    for (int it = 0; it < 200; it++) begin
      sw_a = 16'($urandom); sw_b = 16'($urandom);
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      if (it < 4) begin
        sw_a = (it[0]) ? 16'hFFFF : 16'h8000;
        sw_b = (it[1]) ? 16'h0001 : 16'h7FFF;
      end
      e8  = ref_op(sw_a, sw_b, sw_cin, sw_sub, 8);
      e16 = ref_op(sw_a, sw_b, sw_cin, sw_sub, 16);
      sw_valid = 1'b1;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      sw_a = ~sw_a; sw_b = ~sw_b;
      lw8 = 0; lw1 = 0; ln16 = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (w8_ov && lw8 == 0) lw8 = k;
        if (w1_ov && lw1 == 0) lw1 = k;
        if (n16_ov && ln16 == 0) ln16 = k;
      end
      cmp_sweep("w8", {8'd0, w8_s}, w8_c, w8_o, w8_z, lw8, 1, e8);
      cmp_sweep("w1", {8'd0, w1_s}, w1_c, w1_o, w1_z, lw1, 8, e8);
      cmp_sweep("n16", n16_s, n16_c, n16_o, n16_z, ln16, 4, e16);
      sw_ready = 1'b1;
      @(posedge clk); #1;
      sw_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
